moving_avg_filter: RTL and testbench

//  Boxcar moving-average stage directly downstream of the LTC2308 ADC interface.

---
 rtl/moving_avg_pkg.sv | 8 +
 rtl/moving_avg_filter_if.sv | 23 ++
 rtl/moving_avg_filter_ring_buf.sv | 34 +++
 rtl/moving_avg_filter.sv | 94 +++++++++
 tb/tb_moving_avg_filter.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/moving_avg_pkg.sv
// Shared types and widths for the ADC front end and the moving-average stage.
package moving_avg_pkg;

   localparam int unsigned ADC_DATA_W = 12;

   typedef enum logic [0:0] {S_FILL, S_RUN} mavg_state_t;

endpackage

// File: rtl/moving_avg_filter_if.sv
// Sample-in / average-out bus between the ADC interface and the moving-average stage.
interface moving_avg_filter_if
   import moving_avg_pkg::*;
#(
   parameter int unsigned DATA_W = ADC_DATA_W
);
   logic              clr;
   logic [DATA_W-1:0] sample_in;
   logic              sample_valid;
   logic [DATA_W-1:0] avg_out;
   logic              avg_valid;
   logic              primed;

   modport master (
      output clr, sample_in, sample_valid,
      input  avg_out, avg_valid, primed
   );

   modport slave (
      input  clr, sample_in, sample_valid,
      output avg_out, avg_valid, primed
   );
endinterface

// File: rtl/moving_avg_filter_ring_buf.sv
// Sample ring buffer: writes at a wrapping pointer and exposes the entry about to be
// overwritten so the caller can retire it from a running sum.
module sample_ring_buf #(
   parameter int unsigned DATA_W     = 12,
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] old_data_c
);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;

   assign old_data_c = mem[wr_ptr];

   // Zeroed contents keep the retired sample at 0 until the window has filled once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[wr_ptr] <= wdata;
         wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
      end
   end
endmodule

// File: rtl/moving_avg_filter.sv
// Boxcar moving average over the last 2**LOG2_N ADC samples.
// Build option: define MOVAVG_ROUND_EN to round to nearest instead of truncating.
module moving_avg_filter
   import moving_avg_pkg::*;
#(
   parameter int unsigned DATA_W = ADC_DATA_W,
   parameter int unsigned LOG2_N = 3
) (
   input logic                 clk,
   input logic                 reset,
   moving_avg_filter_if.slave  bus
);
   localparam int unsigned N     = 1 << LOG2_N;
   localparam int unsigned SUM_W = DATA_W + LOG2_N;

   mavg_state_t       state, state_nxt;
   logic [LOG2_N-1:0] fill_cnt;
   logic [SUM_W-1:0]  sum;
   logic [SUM_W-1:0]  new_sum_c;
   logic [DATA_W-1:0] old_data_c;
   logic [DATA_W-1:0] avg_c;
   logic              accept_c;
   logic              emit_c;

   assign accept_c = bus.sample_valid & ~bus.clr;

   sample_ring_buf #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (LOG2_N)
   ) u_ring_buf (
      .clk        (clk),
      .reset      (reset),
      .clr        (bus.clr),
      .we         (accept_c),
      .wdata      (bus.sample_in),
      .old_data_c (old_data_c)
   );

   assign new_sum_c = sum + SUM_W'(bus.sample_in) - SUM_W'(old_data_c);

`ifdef MOVAVG_ROUND_EN
   localparam int unsigned RND_W = SUM_W + 1;
   localparam int unsigned HALF  = 1 << (LOG2_N - 1);
   logic [RND_W-1:0] rnd_sum_c;
   assign rnd_sum_c = RND_W'(new_sum_c) + RND_W'(HALF);
   assign avg_c     = DATA_W'(rnd_sum_c >> LOG2_N);
`else
   assign avg_c     = DATA_W'(new_sum_c >> LOG2_N);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FILL;
      else       state <= state_nxt;
   end

   // An output is emitted for the accept that completes the window and every accept after it.
   always_comb begin
      state_nxt = state;
      emit_c    = 1'b0;
      if (bus.clr) begin
         state_nxt = S_FILL;
      end else if (accept_c) begin
         case (state)
            S_FILL: if (fill_cnt == LOG2_N'(N - 1)) begin
               state_nxt = S_RUN;
               emit_c    = 1'b1;
            end
            S_RUN:  emit_c = 1'b1;
            default: state_nxt = S_FILL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum           <= '0;
         fill_cnt      <= '0;
         bus.avg_out   <= '0;
         bus.avg_valid <= 1'b0;
         bus.primed    <= 1'b0;
      end else begin
         bus.avg_valid <= emit_c;
         bus.primed    <= (state_nxt == S_RUN);
         if (bus.clr) begin
            sum      <= '0;
            fill_cnt <= '0;
         end else if (accept_c) begin
            sum <= new_sum_c;
            if (state == S_FILL) fill_cnt <= fill_cnt + LOG2_N'(1);
         end
         if (emit_c) bus.avg_out <= avg_c;
      end
   end
endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed scoreboard bench for moving_avg_filter (N=8, DATA_W=12).
module tb_moving_avg_filter;
   import moving_avg_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   moving_avg_filter_if #(.DATA_W(12)) bus ();

   moving_avg_filter #(.DATA_W(12), .LOG2_N(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [11:0] exp_q [$];

   // Reference window model.
   int          win [8];
   int          wp;
   int          cnt;
   int          msum;
   logic [11:0] m_avg;
   logic        m_primed;

   function automatic void model_clear(input logic full_reset);
      for (int i = 0; i < 8; i++) win[i] = 0;
      wp = 0; cnt = 0; msum = 0; m_primed = 1'b0;
      if (full_reset) m_avg = 12'd0;
   endfunction

   function automatic void model_accept(input int s);
      int a;
      msum    = msum + s - win[wp];
      win[wp] = s;
      wp      = (wp + 1) % 8;
      if (cnt < 8) cnt++;
      if (cnt == 8) begin
`ifdef MOVAVG_ROUND_EN
         a = (msum + 4) / 8;
`else
         a = msum / 8;
`endif
         m_avg    = 12'(a);
         m_primed = 1'b1;
         exp_q.push_back(m_avg);
      end
   endfunction

   task automatic cmp(input string tag, input int obs, input int expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [11:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cmp({tag, "_valid"}, int'(bus.avg_valid), 1);
         cmp({tag, "_avg"}, int'(bus.avg_out), int'(e));
      end else begin
         cmp({tag, "_novalid"}, int'(bus.avg_valid), 0);
         cmp({tag, "_hold"}, int'(bus.avg_out), int'(m_avg));
      end
      cmp({tag, "_primed"}, int'(bus.primed), int'(m_primed));
   endtask

   task automatic step(input logic v, input int d, input logic c, input string tag);
      bus.sample_valid = v;
      bus.sample_in    = 12'(d);
      bus.clr          = c;
      if (c)      model_clear(1'b0);
      else if (v) model_accept(d);
      @(posedge clk);
      #1;
      bus.sample_valid = 1'b0;
      bus.clr          = 1'b0;
      check_outputs(tag);
   endtask

   initial begin
      reset            = 1'b1;
      bus.clr          = 1'b0;
      bus.sample_in    = '0;
      bus.sample_valid = 1'b0;
      model_clear(1'b1);

      // 1: reset then idle
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_outputs("reset");
      repeat (3) step(1'b0, 0, 1'b0, "idle");

      // 2: fill with 100
      for (int i = 0; i < 8; i++) step(1'b1, 100, 1'b0, "fill100");

      // 3: ramp to 900
      for (int i = 0; i < 8; i++) step(1'b1, 900, 1'b0, "run900");
      step(1'b0, 0, 1'b0, "gap");

      // 4: full scale after clr
      step(1'b0, 0, 1'b1, "clr1");
      for (int i = 0; i < 8; i++) step(1'b1, 4095, 1'b0, "full");

      // 5: ramp 0..7, truncation vs rounding
      step(1'b0, 0, 1'b1, "clr2");
      for (int i = 0; i < 8; i++) step(1'b1, i, 1'b0, "ramp");

      // 6: clr collides with a sample in S_RUN
      step(1'b1, 500, 1'b1, "clr_wins");
      for (int i = 0; i < 7; i++) step(1'b1, 50 + i, 1'b0, "refill");
      step(1'b1, 57, 1'b0, "refill_done");
      step(1'b1, 1000, 1'b0, "refill_run");

      // async reset mid-fill
      step(1'b0, 0, 1'b1, "clr3");
      for (int i = 0; i < 3; i++) step(1'b1, 2000, 1'b0, "prefill");
      #2;
      reset = 1'b1;
      #1;
      model_clear(1'b1);
      cmp("async_rst_avg", int'(bus.avg_out), 0);
      cmp("async_rst_valid", int'(bus.avg_valid), 0);
      cmp("async_rst_primed", int'(bus.primed), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b1, 40, 1'b0, "after_rst");
      step(1'b0, 0, 1'b0, "tail");

      cmp("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
